ui_overlay_addr_gen: RTL
========================

// Module: ui_overlay_addr_gen
// PURPOSE
// - Pipelined, parametrised UI overlay address generator for the VGA path. It sits between the
//   VGA timing counters and the UI sprite-sheet ROM.
// - Per pixel, it maps (h_cnt, v_cnt) and the game state to a sprite-sheet read address plus a
//   hit flag. Covered elements: title, stage buttons, stage header, find/life labels, key icons
//   and life icons.
// - New in this generation: configurable scale, icon counts and sheet size; frame-synchronous
//   capture of state inputs (no tearing); blinking of the selected button.
// PARAMETERS
// - SCALE_SHIFT  1      screen-to-sheet shift; x = h_cnt>>SCALE_SHIFT, y = v_cnt>>SCALE_SHIFT
// - SHEET_W      320    sprite-sheet width in pixels
// - SHEET_SIZE   76800  sheet words; address wraps modulo this value
// - ADDR_W       17     pixel_addr width; must hold SHEET_SIZE-1
// - NUM_KEYS     3      key icon slots, 20x20 each, at screen x = 20*i, y = 50
// - MAX_LIVES    3      life icon slots, 20x20 each, right-aligned at y = 70
// - BLINK_FRAMES 30     frames per blink phase of the selected button
// PORTS
// - clk        in   1                      system clock
// - rst_n      in   1                      asynchronous, active-low reset
// - pix_en     in   1                      pixel-rate enable; pipeline advances only when high
// - valid_in   in   1                      active-video qualifier for h_cnt/v_cnt
// - h_cnt      in   10                     horizontal pixel counter
// - v_cnt      in   10                     vertical pixel counter
// - state      in   4                      game state (encoding from ui_pkg)
// - key_find   in   $clog2(NUM_KEYS+1)     keys found so far
// - lives      in   $clog2(MAX_LIVES+1)    remaining lives
// - sel_btn    in   2                      selected stage button on TITLE (0..2; 3 = none)
// - pixel_addr out  ADDR_W                 sheet read address
// - hit        out  1                      pixel is inside a visible UI element
// - valid_out  out  1                      valid_in delayed to align with pixel_addr/hit
// - blink_on   out  1                      current blink phase (1 = selected button shown)
// BEHAVIOUR
// - Reset: pixel_addr=0, hit=0, valid_out=0, blink_on=1, blink counter=0.
//   Shadow registers reset to state=TITLE, key_find=0, lives=0, sel_btn=3.
// - Frame tick = pix_en & (h_cnt==0) & (v_cnt==0). On a frame tick:
//   - shadow registers capture state, key_find, lives and sel_btn;
//   - the blink counter increments;
//   - at BLINK_FRAMES-1 the counter clears and blink_on toggles.
//   All decoding uses the shadow registers, never the live inputs.
// - Pipeline: latency 2 pix_en-qualified cycles; no stall. With pix_en low, all registers hold.
//   - S1 registers x, y, the matched region id and the sheet origin.
//   - S2 registers the address and hit.
// - Address arithmetic:
//   - a = (x - rx0 + sx0) + (y - ry0 + sy0)*SHEET_W;
//   - if a >= SHEET_SIZE, a -= SHEET_SIZE (single conditional subtract; no % operator).
// - Region table (screen rectangle -> sheet origin), first match wins:
//   - TITLE: title 240x60 @(40,40) -> (60,80).
//   - TITLE: stage buttons 80x20 @(120,120/160/200) -> (140,40)/(0,60)/(80,60).
//   - STAGEn: header 80x20 @(120,0).
//   - STAGEn: find label 60x20 @(0,30) -> (0,160).
//   - STAGEn: life label 60x20 @(260,30) -> (60,160).
//   - STAGEn: key icon i 20x20 @(20i,50) -> (0,80), visible iff i < key_find.
//   - STAGEn: life icon i 20x20 @(300-20i,70) -> (20,80), visible iff i < lives.
// - Selected button: when blink_on=0, the button at index sel_btn reports hit=0 and pixel_addr=0.
// - Clamping: key_find > NUM_KEYS is treated as NUM_KEYS; lives > MAX_LIVES as MAX_LIVES.
// - Boundaries: no match, valid_in=0, or an unknown state -> hit=0, pixel_addr=0.
//   Rectangle bounds are inclusive of the lower edge and exclusive of the upper edge.
// - Simultaneous events: a state change mid-frame takes effect at the next frame tick.
//   A frame tick and blink wrap in the same cycle toggle blink_on exactly once.
// - Reset mid-frame: outputs drop to their reset values immediately (asynchronous).
//   Normal output resumes 2 pix_en cycles after rst_n rises.
// STRUCTURE
// - ui_pkg: state encodings (TITLE, STAFF, STAGE1..3, SUCCESS1..3, FAIL), region ids,
//   rectangle/origin constants, icon size 20.
// - Sub-module ui_rect_match: parameters RX0, RY0, W, H. Inputs x, y. Outputs in_rect and
//   offsets (x-RX0, y-RY0). Instanced once per region via generate.
// TESTING
// - TITLE, h=100, v=100, pix_en=1 -> 2 cycles later: hit=1, pixel_addr=28870.
// - STAGE1, key_find=2, h=50, v=110 -> hit=1, pixel_addr=27205.
//   Same frame, h=90 -> hit=0, pixel_addr=0.
// - key_find changes 1->3 mid-frame -> key3 stays hidden until the next frame tick, then hit=1.
// - TITLE, sel_btn=0, 30 frame ticks -> blink_on=0 and the stage1 button pixel (h=260,v=260) has
//   hit=0. After 30 more ticks -> blink_on=1 and hit=1.
// - state=4'hF or valid_in=0 -> hit=0, pixel_addr=0. pix_en held low 5 cycles -> outputs frozen.
// - rst_n low for 1 cycle mid-line -> all outputs at reset values asynchronously;
//   valid_out returns 2 pix_en cycles after release.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared encodings and screen/sheet geometry for the UI overlay address generator.
// Screen coordinates are in sheet pixels, i.e. already divided down by the scale shift.
package ui_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_STAGE2   = 4'd3,
        ST_STAGE3   = 4'd4,
        ST_SUCCESS1 = 4'd5,
        ST_SUCCESS2 = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } ui_state_e;

    typedef enum logic [2:0] {
        RG_NONE,
        RG_TITLE,
        RG_BTN,
        RG_HEADER,
        RG_FIND,
        RG_LIFE,
        RG_KEY,
        RG_HEART
    } region_e;

    localparam int ICON = 20;

    localparam int TITLE_X  = 40;
    localparam int TITLE_Y  = 40;
    localparam int TITLE_W  = 240;
    localparam int TITLE_H  = 60;
    localparam int TITLE_SX = 60;
    localparam int TITLE_SY = 80;

    localparam int NUM_BTN   = 3;
    localparam int BTN_X     = 120;
    localparam int BTN_Y     = 120;
    localparam int BTN_PITCH = 40;
    localparam int BTN_W     = 80;
    localparam int BTN_H     = 20;

    localparam int HDR_X = 120;
    localparam int HDR_Y = 0;

    localparam int LBL_W   = 60;
    localparam int LBL_H   = 20;
    localparam int FIND_X  = 0;
    localparam int FIND_Y  = 30;
    localparam int FIND_SX = 0;
    localparam int FIND_SY = 160;
    localparam int LIFE_X  = 260;
    localparam int LIFE_Y  = 30;
    localparam int LIFE_SX = 60;
    localparam int LIFE_SY = 160;

    localparam int KEY_Y    = 50;
    localparam int KEY_SX   = 0;
    localparam int KEY_SY   = 80;
    localparam int HEART_X  = 300;
    localparam int HEART_Y  = 70;
    localparam int HEART_SX = 20;
    localparam int HEART_SY = 80;

    // Stage buttons and the stage header share artwork: header of stage n is button n.
    function automatic logic [9:0] btn_origin_x(input logic [1:0] idx);
        case (idx)
            2'd0:    return 10'd140;
            2'd1:    return 10'd0;
            default: return 10'd80;
        endcase
    endfunction

    function automatic logic [9:0] btn_origin_y(input logic [1:0] idx);
        case (idx)
            2'd0:    return 10'd40;
            default: return 10'd60;
        endcase
    endfunction

    function automatic logic is_stage(input logic [3:0] s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

    function automatic logic [1:0] stage_idx(input logic [3:0] s);
        case (s)
            ST_STAGE2: return 2'd1;
            ST_STAGE3: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ui_rect_match.sv
// Rectangle hit test: lower edges inclusive, upper edges exclusive, plus local offsets.
module ui_rect_match #(
    parameter int RX0 = 0,
    parameter int RY0 = 0,
    parameter int W   = 1,
    parameter int H   = 1
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       in_rect,
    output logic [9:0] dx,
    output logic [9:0] dy
);

    // Points left of / above the origin wrap to large values and fail the width test.
    assign dx      = x - 10'(RX0);
    assign dy      = y - 10'(RY0);
    assign in_rect = (dx < 10'(W)) && (dy < 10'(H));

endmodule

// File: rtl/ui_overlay_addr_gen.sv
// Two-stage UI overlay address generator: screen pixel + frame-latched game state
// in, sprite-sheet address and hit flag out.
module ui_overlay_addr_gen
    import ui_pkg::*;
#(
    parameter int SCALE_SHIFT  = 1,
    parameter int SHEET_W      = 320,
    parameter int SHEET_SIZE   = 76800,
    parameter int ADDR_W       = 17,
    parameter int NUM_KEYS     = 3,
    parameter int MAX_LIVES    = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_en,
    input  logic                           valid_in,
    input  logic [9:0]                     h_cnt,
    input  logic [9:0]                     v_cnt,
    input  logic [3:0]                     state,
    input  logic [$clog2(NUM_KEYS+1)-1:0]  key_find,
    input  logic [$clog2(MAX_LIVES+1)-1:0] lives,
    input  logic [1:0]                     sel_btn,
    output logic [ADDR_W-1:0]              pixel_addr,
    output logic                           hit,
    output logic                           valid_out,
    output logic                           blink_on
);

    localparam int KF_W = $clog2(NUM_KEYS+1);
    localparam int LV_W = $clog2(MAX_LIVES+1);
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]      x, y;
    logic            frame_tick;
    logic [3:0]      sh_state;
    logic [KF_W-1:0] sh_key;
    logic [LV_W-1:0] sh_lives;
    logic [1:0]      sh_sel;
    logic [BL_W-1:0] blink_cnt;

    assign x          = h_cnt >> SCALE_SHIFT;
    assign y          = v_cnt >> SCALE_SHIFT;
    assign frame_tick = pix_en && (h_cnt == '0) && (v_cnt == '0);

    // Game state is only sampled at the frame origin so one frame never mixes two states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_state  <= ST_TITLE;
            sh_key    <= '0;
            sh_lives  <= '0;
            sh_sel    <= 2'd3;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            sh_state <= state;
            sh_key   <= key_find;
            sh_lives <= lives;
            sh_sel   <= sel_btn;
            if (blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end
    end

    logic                title_in;
    logic [9:0]          title_dx, title_dy;
    logic [NUM_BTN-1:0]  btn_in;
    logic [9:0]          btn_dx [NUM_BTN];
    logic [9:0]          btn_dy [NUM_BTN];
    logic                hdr_in, find_in, life_in;
    logic [9:0]          hdr_dx, hdr_dy, find_dx, find_dy, life_dx, life_dy;
    logic [NUM_KEYS-1:0] key_in;
    logic [9:0]          key_dx [NUM_KEYS];
    logic [9:0]          key_dy [NUM_KEYS];
    logic [MAX_LIVES-1:0] heart_in;
    logic [9:0]          heart_dx [MAX_LIVES];
    logic [9:0]          heart_dy [MAX_LIVES];

    ui_rect_match #(.RX0(TITLE_X), .RY0(TITLE_Y), .W(TITLE_W), .H(TITLE_H)) u_title (
        .x(x), .y(y), .in_rect(title_in), .dx(title_dx), .dy(title_dy)
    );

    ui_rect_match #(.RX0(HDR_X), .RY0(HDR_Y), .W(BTN_W), .H(BTN_H)) u_header (
        .x(x), .y(y), .in_rect(hdr_in), .dx(hdr_dx), .dy(hdr_dy)
    );

    ui_rect_match #(.RX0(FIND_X), .RY0(FIND_Y), .W(LBL_W), .H(LBL_H)) u_find (
        .x(x), .y(y), .in_rect(find_in), .dx(find_dx), .dy(find_dy)
    );

    ui_rect_match #(.RX0(LIFE_X), .RY0(LIFE_Y), .W(LBL_W), .H(LBL_H)) u_life (
        .x(x), .y(y), .in_rect(life_in), .dx(life_dx), .dy(life_dy)
    );

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        ui_rect_match #(.RX0(BTN_X), .RY0(BTN_Y + BTN_PITCH*b), .W(BTN_W), .H(BTN_H)) u_btn (
            .x(x), .y(y), .in_rect(btn_in[b]), .dx(btn_dx[b]), .dy(btn_dy[b])
        );
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        ui_rect_match #(.RX0(ICON*i), .RY0(KEY_Y), .W(ICON), .H(ICON)) u_key (
            .x(x), .y(y), .in_rect(key_in[i]), .dx(key_dx[i]), .dy(key_dy[i])
        );
    end

    for (genvar i = 0; i < MAX_LIVES; i++) begin : g_heart
        ui_rect_match #(.RX0(HEART_X - ICON*i), .RY0(HEART_Y), .W(ICON), .H(ICON)) u_heart (
            .x(x), .y(y), .in_rect(heart_in[i]), .dx(heart_dx[i]), .dy(heart_dy[i])
        );
    end

    region_e    dec_kind;
    logic       dec_vis;
    logic [9:0] dec_sx, dec_sy;

    // First match in table order wins. Icon visibility compares the slot index against
    // the count, so counts above the slot total behave as if clamped.
    always_comb begin
        dec_kind = RG_NONE;
        dec_vis  = 1'b0;
        dec_sx   = '0;
        dec_sy   = '0;
        if (valid_in) begin
            if (sh_state == ST_TITLE) begin
                if (title_in) begin
                    dec_kind = RG_TITLE;
                    dec_vis  = 1'b1;
                    dec_sx   = title_dx + 10'(TITLE_SX);
                    dec_sy   = title_dy + 10'(TITLE_SY);
                end
                for (int b = 0; b < NUM_BTN; b++) begin
                    if (dec_kind == RG_NONE && btn_in[b]) begin
                        dec_kind = RG_BTN;
                        dec_vis  = blink_on || (sh_sel != 2'(b));
                        dec_sx   = btn_dx[b] + btn_origin_x(2'(b));
                        dec_sy   = btn_dy[b] + btn_origin_y(2'(b));
                    end
                end
            end else if (is_stage(sh_state)) begin
                if (hdr_in) begin
                    dec_kind = RG_HEADER;
                    dec_vis  = 1'b1;
                    dec_sx   = hdr_dx + btn_origin_x(stage_idx(sh_state));
                    dec_sy   = hdr_dy + btn_origin_y(stage_idx(sh_state));
                end else if (find_in) begin
                    dec_kind = RG_FIND;
                    dec_vis  = 1'b1;
                    dec_sx   = find_dx + 10'(FIND_SX);
                    dec_sy   = find_dy + 10'(FIND_SY);
                end else if (life_in) begin
                    dec_kind = RG_LIFE;
                    dec_vis  = 1'b1;
                    dec_sx   = life_dx + 10'(LIFE_SX);
                    dec_sy   = life_dy + 10'(LIFE_SY);
                end
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (dec_kind == RG_NONE && key_in[i]) begin
                        dec_kind = RG_KEY;
                        dec_vis  = KF_W'(i) < sh_key;
                        dec_sx   = key_dx[i] + 10'(KEY_SX);
                        dec_sy   = key_dy[i] + 10'(KEY_SY);
                    end
                end
                for (int i = 0; i < MAX_LIVES; i++) begin
                    if (dec_kind == RG_NONE && heart_in[i]) begin
                        dec_kind = RG_HEART;
                        dec_vis  = LV_W'(i) < sh_lives;
                        dec_sx   = heart_dx[i] + 10'(HEART_SX);
                        dec_sy   = heart_dy[i] + 10'(HEART_SY);
                    end
                end
            end
        end
    end

    logic       s1_valid;
    region_e    s1_kind;
    logic       s1_vis;
    logic [9:0] s1_sx, s1_sy;
    logic [31:0] a_raw, a_wrap;
    logic       s2_hit;

    assign a_raw  = 32'(s1_sy) * 32'(SHEET_W) + 32'(s1_sx);
    assign a_wrap = (a_raw >= 32'(SHEET_SIZE)) ? a_raw - 32'(SHEET_SIZE) : a_raw;
    assign s2_hit = s1_vis && (s1_kind != RG_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_kind    <= RG_NONE;
            s1_vis     <= 1'b0;
            s1_sx      <= '0;
            s1_sy      <= '0;
            valid_out  <= 1'b0;
            hit        <= 1'b0;
            pixel_addr <= '0;
        end else if (pix_en) begin
            s1_valid   <= valid_in;
            s1_kind    <= dec_kind;
            s1_vis     <= dec_vis;
            s1_sx      <= dec_sx;
            s1_sy      <= dec_sy;
            valid_out  <= s1_valid;
            hit        <= s2_hit;
            pixel_addr <= s2_hit ? ADDR_W'(a_wrap) : '0;
        end
    end

endmodule
